// File: rtl/led_move_ctrl.sv
// led_move_ctrl: debounced start/stop/step buttons -> run state, step strobe, 4-bit position
//   CLK, nrst (async, active-low)
//   btn_start, btn_stop, btn_step : raw asynchronous push-buttons, active-high
//   run  : high in RUN state
//   step : one-cycle advance strobe (divided auto step or manual step)
//   pos  : position 0..15, advances on every step
//   wrap : high with the step that takes pos from 15 to 0
module led_move_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int STEP_DIV = 8
) (
  input  logic       CLK,
  input  logic       nrst,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_step,
  output logic       run,
  output logic       step,
  output logic [3:0] pos,
  output logic       wrap
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int DW = $clog2(STEP_DIV);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
  typedef enum logic {STOP, RUN} state_t;
  state_t state;
  logic [2:0] btn, s1, s2, deb, deb_d, ev;
  logic [CW-1:0] cnt [3];
  logic [DW-1:0] div_cnt;
  logic man;
  assign btn = {btn_step, btn_stop, btn_start};
  always_ff @(posedge CLK or negedge nrst)
    if (!nrst) begin
      s1 <= '0;
      s2 <= '0;
      deb <= '0;
      deb_d <= '0;
      ev <= '0;
      for (int b = 0; b < 3; b++) cnt[b] <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      deb_d <= deb;
      ev <= deb & ~deb_d;
      for (int b = 0; b < 3; b++)
        if (s2[b] == deb[b]) cnt[b] <= '0;
        else if (cnt[b] == DEB_LAST) begin
          cnt[b] <= '0;
          deb[b] <= ~deb[b];
        end else cnt[b] <= cnt[b] + 1'b1;
    end
  // ev[0]=start, ev[1]=stop, ev[2]=step; stop has priority over start
  always_ff @(posedge CLK or negedge nrst)
    if (!nrst) begin
      state <= STOP;
      div_cnt <= '0;
      man <= 1'b0;
      pos <= '0;
    end else begin
      state <= ev[1] ? STOP : ev[0] ? RUN : state;
      div_cnt <= (state == RUN && div_cnt != DIV_LAST) ? div_cnt + 1'b1 : '0;
      man <= ev[2] && state == STOP;
      if (step) pos <= pos + 4'd1;
    end
  assign run = state == RUN;
  // a stop event in the divider's terminal cycle cancels that auto step
  assign step = (run && div_cnt == DIV_LAST && !ev[1]) || man;
  assign wrap = step && pos == 4'hF;
endmodule

// File: tb/tb_led_move_ctrl.sv
// tb_led_move_ctrl: scoreboard bench for led_move_ctrl (DEB_CYCLES=4, STEP_DIV=8)
module tb_led_move_ctrl;
  logic CLK = 1'b0, nrst = 1'b0, btn_start = 1'b0, btn_stop = 1'b0, btn_step = 1'b0;
  logic run, step, wrap, prev_step = 1'b0;
  logic [3:0] pos, exp_pos = 4'd0;
  typedef struct {int e; logic [3:0] p; logic w;} exp_t;
  exp_t q[$];
  exp_t mx;
  int cyc = 0, checks = 0, failures = 0, steps_seen = 0, r = 0;
  led_move_ctrl #(.DEB_CYCLES(4), .STEP_DIV(8)) dut (
    .CLK(CLK), .nrst(nrst), .btn_start(btn_start), .btn_stop(btn_stop), .btn_step(btn_step),
    .run(run), .step(step), .pos(pos), .wrap(wrap)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;
  // each expected step: edge after which it is high, pos during it, wrap during it
  always @(negedge CLK) begin
    if (nrst && step) begin
      steps_seen++;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_step edge=%0d pos=%0d", cyc, pos);
      end else begin
        mx = q.pop_front();
        if (cyc !== mx.e || pos !== mx.p || wrap !== mx.w) begin
          failures++;
          $display("FAIL step_sb got edge=%0d pos=%0d wrap=%0b exp edge=%0d pos=%0d wrap=%0b",
                   cyc, pos, wrap, mx.e, mx.p, mx.w);
        end
      end
      checks++;
      if (prev_step !== 1'b0) begin
        failures++;
        $display("FAIL step_consecutive edge=%0d", cyc);
      end
    end else if (nrst) begin
      checks++;
      if (wrap !== 1'b0) begin
        failures++;
        $display("FAIL wrap_without_step edge=%0d wrap=%0b exp=0", cyc, wrap);
      end
    end
    prev_step = nrst & step;
  end
  task automatic push_step(input int e);
    q.push_back(exp_t'{e: e, p: exp_pos, w: (exp_pos == 4'hF)});
    exp_pos++;
  endtask
  // returns at the negedge just before edge e, so inputs driven now are sampled at e
  task automatic goto(input int e);
    while (cyc < e - 1) @(negedge CLK);
  endtask
  task automatic check_idle(input string name, input logic [3:0] p);
    checks++;
    if (run !== 1'b0 || pos !== p) begin
      failures++;
      $display("FAIL %s got run=%0b pos=%0d exp run=0 pos=%0d", name, run, pos, p);
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_steps got %0d pending exp 0", name, q.size());
    end
  endtask
  task automatic test_reset;
    int s0;
    nrst = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({run, step, wrap, pos} !== 7'd0) begin
      failures++;
      $display("FAIL reset_outputs got run=%0b step=%0b wrap=%0b pos=%0d exp all 0", run, step, wrap, pos);
    end
    nrst = 1'b1;
    s0 = steps_seen;
    repeat (100) @(negedge CLK);
    checks++;
    if (steps_seen - s0 != 0) begin
      failures++;
      $display("FAIL idle_steps got %0d exp 0", steps_seen - s0);
    end
    check_idle("idle", 4'd0);
  endtask
  task automatic test_run_steps;
    int k;
    k = cyc + 1;
    btn_start = 1'b1;
    r = k + 7;
    for (int j = 0; j < 17; j++) push_step(r + 7 + 8 * j);
    goto(r);
    checks++;
    if (run !== 1'b0) begin
      failures++;
      $display("FAIL run_early got %0b exp 0", run);
    end
    @(negedge CLK);
    checks++;
    if (run !== 1'b1) begin
      failures++;
      $display("FAIL run_rise got %0b exp 1", run);
    end
    @(negedge CLK);
    btn_start = 1'b0;
    goto(r + 7 + 8 * 16 + 2);
    checks++;
    if (pos !== 4'd1 || q.size() != 0) begin
      failures++;
      $display("FAIL pos_after_wrap got pos=%0d pending=%0d exp pos=1 pending=0", pos, q.size());
    end
  endtask
  task automatic test_stop_terminal;
    for (int j = 17; j < 20; j++) push_step(r + 7 + 8 * j);
    goto(r + 161);
    btn_stop = 1'b1;
    btn_start = 1'b1;
    goto(r + 168);
    checks++;
    if (step !== 1'b0) begin
      failures++;
      $display("FAIL step_on_stop got %0b exp 0", step);
    end
    @(negedge CLK);
    btn_stop = 1'b0;
    btn_start = 1'b0;
    checks++;
    if (run !== 1'b0) begin
      failures++;
      $display("FAIL stop_wins_in_run got run=%0b exp 0", run);
    end
    repeat (20) @(negedge CLK);
    check_idle("stop_terminal", 4'd4);
  endtask
  task automatic test_bounce;
    int s0;
    s0 = steps_seen;
    for (int i = 0; i < 10; i++) begin
      btn_start = ~btn_start;
      repeat (2) @(negedge CLK);
    end
    btn_start = 1'b0;
    repeat (20) @(negedge CLK);
    checks++;
    if (steps_seen - s0 != 0) begin
      failures++;
      $display("FAIL bounce_steps got %0d exp 0", steps_seen - s0);
    end
    check_idle("bounce", 4'd4);
  endtask
  task automatic test_simultaneous;
    btn_start = 1'b1;
    btn_stop = 1'b1;
    repeat (15) @(negedge CLK);
    check_idle("simultaneous", 4'd4);
    btn_start = 1'b0;
    btn_stop = 1'b0;
    repeat (15) @(negedge CLK);
  endtask
  task automatic test_manual_step;
    int s0, k;
    s0 = steps_seen;
    for (int i = 0; i < 3; i++) begin
      k = cyc + 1;
      btn_step = 1'b1;
      push_step(k + 7);
      repeat (10) @(negedge CLK);
      btn_step = 1'b0;
      repeat (10) @(negedge CLK);
    end
    checks++;
    if (steps_seen - s0 != 3) begin
      failures++;
      $display("FAIL manual_count got %0d exp 3", steps_seen - s0);
    end
    check_idle("manual", 4'd7);
  endtask
  task automatic test_step_in_run;
    int k;
    k = cyc + 1;
    btn_start = 1'b1;
    r = k + 7;
    for (int j = 0; j < 8; j++) push_step(r + 7 + 8 * j);
    for (int i = 0; i < 3; i++) begin
      goto(r + 2 + 20 * i);
      btn_start = 1'b0;
      btn_step = 1'b1;
      goto(r + 12 + 20 * i);
      btn_step = 1'b0;
    end
    goto(r + 60);
    btn_stop = 1'b1;
    goto(r + 67);
    checks++;
    if (run !== 1'b1) begin
      failures++;
      $display("FAIL run_before_stop got %0b exp 1", run);
    end
    goto(r + 70);
    btn_stop = 1'b0;
    goto(r + 90);
    check_idle("step_in_run", 4'd15);
  endtask
  task automatic test_reset_mid;
    int k, n, l;
    n = (25 - int'(exp_pos)) % 16;
    n = (n == 0) ? 16 : n;
    k = cyc + 1;
    btn_start = 1'b1;
    r = k + 7;
    for (int j = 0; j < n; j++) push_step(r + 7 + 8 * j);
    goto(r + 3);
    btn_start = 1'b0;
    l = r + 7 + 8 * (n - 1);
    goto(l + 3);
    checks++;
    if (pos !== 4'd9 || run !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got pos=%0d run=%0b exp pos=9 run=1", pos, run);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({run, step, wrap, pos} !== 7'd0) begin
      failures++;
      $display("FAIL reset_mid got run=%0b step=%0b wrap=%0b pos=%0d exp all 0", run, step, wrap, pos);
    end
    exp_pos = 4'd0;
    @(negedge CLK);
    nrst = 1'b1;
    repeat (20) @(negedge CLK);
    check_idle("after_reset_mid", 4'd0);
  endtask
  initial begin
    @(negedge CLK);
    test_reset;
    test_run_steps;
    test_stop_terminal;
    test_bounce;
    test_simultaneous;
    test_manual_step;
    test_step_in_run;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
